// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM slave.
// Handshake and payload signals for all five channels.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed SRAM array.
// Independent read/write FSMs, one outstanding burst each.
module axi_sram_slave #(
  parameter int          MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
  input logic             aclk,
  input logic             aresetn,
  axi_sram_slave_if.slave bus
);

  localparam int HI = MEM_AW + 2;

  typedef enum logic [1:0] {
    R_IDLE, R_FETCH, R_DATA
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_t;

  logic [31:0] r_mem [2**MEM_AW];

  function automatic logic [31:0] f_next(
    input logic [31:0] a,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    unique case (burst)
      2'b00:   f_next = a;
      2'b10:   f_next = (a & ~mask) | ((a + step) & mask);
      default: f_next = a + step;
    endcase
  endfunction

  function automatic logic f_hit(input logic [31:0] a);
    return a[31:HI] == BASE_ADDR[31:HI];
  endfunction

  // Holds both ready outputs low until the first edge out of reset.
  logic r_live;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_live <= 1'b0;
    else          r_live <= 1'b1;

  rstate_t     r_rs;
  rstate_t     w_rs_nx;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rcnt;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic        w_r_hs;

  assign w_ar_hs = bus.arvalid & bus.arready;
  assign w_r_hs  = bus.rvalid & bus.rready;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_rs <= R_IDLE;
    else          r_rs <= w_rs_nx;

  always_comb begin
    w_rs_nx = r_rs;
    unique case (r_rs)
      R_IDLE:  if (w_ar_hs) w_rs_nx = R_FETCH;
      R_FETCH: w_rs_nx = R_DATA;
      R_DATA:
        if (w_r_hs)
          w_rs_nx = (r_rcnt == 8'd0) ? R_IDLE : R_FETCH;
      default: w_rs_nx = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = r_live & (r_rs == R_IDLE);
    bus.rvalid  = (r_rs == R_DATA);
    bus.rlast   = (r_rs == R_DATA) & (r_rcnt == 8'd0);
    bus.rid     = r_rid;
    bus.rdata   = r_rdata;
    bus.rresp   = r_rresp;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= bus.arid;
        r_raddr  <= bus.araddr;
        r_rlen   <= bus.arlen;
        r_rcnt   <= bus.arlen;
        r_rsize  <= bus.arsize;
        r_rburst <= bus.arburst;
      end
      // Same-cycle write to this word lands after this sample.
      if (r_rs == R_FETCH) begin
        if (!f_hit(r_raddr)) begin
          r_rresp <= 2'b11;
          r_rdata <= '0;
        end else if (r_rsize > 3'd2) begin
          r_rresp <= 2'b10;
          r_rdata <= '0;
        end else begin
          r_rresp <= 2'b00;
          r_rdata <= r_mem[r_raddr[HI-1:2]];
        end
      end
      if (w_r_hs && r_rcnt != 8'd0) begin
        r_raddr <= f_next(r_raddr, r_rlen,
                          r_rsize, r_rburst);
        r_rcnt  <= r_rcnt - 8'd1;
      end
    end

  wstate_t     r_ws;
  wstate_t     w_ws_nx;
  logic [3:0]  r_wid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wcnt;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic        r_wdec;
  logic        r_wslv;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_wok;

  assign w_aw_hs = bus.awvalid & bus.awready;
  assign w_w_hs  = bus.wvalid & bus.wready;
  assign w_b_hs  = bus.bvalid & bus.bready;
  assign w_wok   = f_hit(r_waddr) & (r_wsize <= 3'd2);

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_ws <= W_IDLE;
    else          r_ws <= w_ws_nx;

  always_comb begin
    w_ws_nx = r_ws;
    unique case (r_ws)
      W_IDLE: if (w_aw_hs) w_ws_nx = W_DATA;
      W_DATA:
        if (w_w_hs && r_wcnt == 8'd0)
          w_ws_nx = W_RESP;
      W_RESP: if (w_b_hs) w_ws_nx = W_IDLE;
      default: w_ws_nx = W_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = r_live & (r_ws == W_IDLE);
    bus.wready  = (r_ws == W_DATA);
    bus.bvalid  = (r_ws == W_RESP);
    bus.bid     = r_wid;
    bus.bresp   = 2'b00;
    if (r_ws == W_RESP)
      bus.bresp = r_wdec ? 2'b11 :
                  r_wslv ? 2'b10 : 2'b00;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wdec   <= 1'b0;
      r_wslv   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_wid    <= bus.awid;
        r_waddr  <= bus.awaddr;
        r_wlen   <= bus.awlen;
        r_wcnt   <= bus.awlen;
        r_wsize  <= bus.awsize;
        r_wburst <= bus.awburst;
        r_wdec   <= 1'b0;
        r_wslv   <= 1'b0;
      end
      if (w_w_hs) begin
        if (!f_hit(r_waddr)) r_wdec <= 1'b1;
        if (r_wsize > 3'd2)  r_wslv <= 1'b1;
        if (bus.wlast != (r_wcnt == 8'd0))
          r_wslv <= 1'b1;
        r_waddr <= f_next(r_waddr, r_wlen,
                          r_wsize, r_wburst);
        r_wcnt  <= r_wcnt - 8'd1;
      end
    end

  always_ff @(posedge aclk)
    if (w_w_hs && w_wok)
      for (int i = 0; i < 4; i++)
        if (bus.wstrb[i])
          r_mem[r_waddr[HI-1:2]][8*i +: 8]
            <= bus.wdata[8*i +: 8];

  logic w_unused;
  assign w_unused = ^{bus.arlock, bus.arcache,
                      bus.arprot, bus.awlock,
                      bus.awcache, bus.awprot,
                      bus.wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: randomized and directed
// bursts checked against an address-arithmetic memory model.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h1c000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if bus();

  axi_sram_slave #(
    .MEM_AW(16),
    .BASE_ADDR(BASE)
  ) dut (
    .aclk(clk),
    .aresetn(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // Reference model
  logic [31:0] mm [int unsigned];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  function automatic logic [31:0] beat_addr(
    logic [31:0] s, int len, int size,
    logic [1:0] burst, int i);
    longint unsigned step, bnd, lo, ss;
    step = 64'd1 << size;
    bnd  = longint'(len + 1) * step;
    ss   = s;
    if (burst == 2'b00) return s;
    if (burst == 2'b10) begin
      lo = ss - (ss % bnd);
      return 32'(lo + ((ss - lo + i * step) % bnd));
    end
    return 32'(ss + i * step);
  endfunction

  function automatic bit in_range(logic [31:0] a);
    return (a >> 18) == (BASE >> 18);
  endfunction

  function automatic int unsigned widx(logic [31:0] a);
    return (a >> 2) & 32'hFFFF;
  endfunction

  bit bp = 1'b0;
  int r_beats = 0;
  int r_stall_at = 0;
  int r_stall_left = 0;
  int b_stall_left = 0;

  initial begin
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (r_stall_left > 0 && r_beats >= r_stall_at) begin
        bus.rready = 1'b0;
        r_stall_left--;
      end else
        bus.rready = bp ? ($urandom_range(3) != 0) : 1'b1;
      if (b_stall_left > 0 && bus.bvalid) begin
        bus.bready = 1'b0;
        b_stall_left--;
      end else
        bus.bready = bp ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Monitor
  logic [38:0] r_hold;
  bit r_held = 1'b0;
  logic [5:0] b_hold;
  bit b_held = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_held = 1'b0;
      b_held = 1'b0;
    end else begin
      if (r_held)
        check("r_stable",
              {bus.rvalid, bus.rid, bus.rdata,
               bus.rresp, bus.rlast},
              {1'b1, r_hold});
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("r_beat",
                {bus.rid, bus.rdata, bus.rresp, bus.rlast},
                {e.id, e.data, e.resp, e.last});
        end
        r_beats++;
        r_held = 1'b0;
      end else if (bus.rvalid) begin
        r_hold = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
        r_held = 1'b1;
      end else
        r_held = 1'b0;

      if (b_held)
        check("b_stable",
              {bus.bvalid, bus.bid, bus.bresp},
              {1'b1, b_hold});
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          bexp_t e;
          e = bq.pop_front();
          check("b_resp", {bus.bid, bus.bresp},
                {e.id, e.resp});
        end
        b_held = 1'b0;
      end else if (bus.bvalid) begin
        b_hold = {bus.bid, bus.bresp};
        b_held = 1'b1;
      end else
        b_held = 1'b0;
    end
  end

  task automatic rd_issue(logic [3:0] id, logic [31:0] addr,
                          int len, int size,
                          logic [1:0] burst);
    int n;
    for (int i = 0; i <= len; i++) begin
      rexp_t e;
      logic [31:0] a;
      a = beat_addr(addr, len, size, burst, i);
      e.id = id;
      e.last = (i == len);
      if (!in_range(a)) begin
        e.resp = 2'b11;
        e.data = '0;
      end else if (size > 2) begin
        e.resp = 2'b10;
        e.data = '0;
      end else begin
        e.resp = 2'b00;
        e.data = mm.exists(widx(a)) ? mm[widx(a)] : 'x;
      end
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.arid = id;
    bus.araddr = addr;
    bus.arlen = 8'(len);
    bus.arsize = 3'(size);
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.arready) fail("ar_timeout");
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic rd_wait();
    int n = 0;
    while (rq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      fail("r_timeout");
      rq.delete();
    end
  endtask

  logic [31:0] wd[$];
  logic [3:0]  ws[$];

  task automatic wr(logic [3:0] id, logic [31:0] addr,
                    int len, int size, logic [1:0] burst,
                    int bad_last);
    bit dec = 0;
    bit slv = 0;
    bexp_t be;
    int n;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, len, size, burst, i);
      if (!in_range(a)) dec = 1;
      if (size > 2) slv = 1;
      if (i == bad_last) slv = 1;
      if (in_range(a) && size <= 2) begin
        logic [31:0] w;
        w = mm.exists(widx(a)) ? mm[widx(a)] : 'x;
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        mm[widx(a)] = w;
      end
    end
    be.id = id;
    be.resp = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    bq.push_back(be);

    @(posedge clk);
    #1;
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = 8'(len);
    bus.awsize = 3'(size);
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.awready) fail("aw_timeout");
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (bp && $urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.wid = 4'($urandom);
      bus.wdata = wd[i];
      bus.wstrb = ws[i];
      bus.wlast = (i == len) ^ (i == bad_last);
      bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.wready) fail("w_timeout");
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
    end
    n = 0;
    while (bq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bq.size() != 0) begin
      fail("b_timeout");
      bq.delete();
    end
    wd.delete();
    ws.delete();
  endtask

  task automatic put(logic [31:0] d, logic [3:0] s);
    wd.push_back(d);
    ws.push_back(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, size, st, start;
    logic [1:0] burst;
    logic [31:0] addr;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.arlock = '0;
    bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0; bus.awlock = '0;
    bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.wlast = 1'b0; bus.wvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out",
          {bus.arready, bus.awready, bus.rvalid, bus.wready,
           bus.bvalid, bus.rlast, bus.rid, bus.bid,
           bus.rresp, bus.bresp, bus.rdata},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arready_up", {bus.arready, bus.awready}, 2'b11);

    for (int i = 0; i < 64; i++) put($urandom, 4'hF);
    wr(4'd1, BASE, 63, 2, 2'b01, -1);

    put(32'hDEADBEEF, 4'hF);
    wr(4'd1, BASE + 32'h10, 0, 2, 2'b01, -1);
    rd_issue(4'd3, BASE + 32'h10, 0, 2, 2'b01);
    check("lat_fetch", bus.rvalid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_data", bus.rvalid, 1'b1);
    rd_wait();

    put(32'hAABBCCDD, 4'hF);
    wr(4'd2, BASE + 32'h20, 0, 2, 2'b01, -1);
    put(32'h11223344, 4'b0101);
    wr(4'd5, BASE + 32'h20, 0, 2, 2'b01, -1);
    check("strb_model", mm[widx(BASE + 32'h20)],
          32'hAA22CC44);
    rd_issue(4'd6, BASE + 32'h20, 0, 2, 2'b01);
    rd_wait();

    for (int i = 1; i <= 4; i++) put(32'(i), 4'hF);
    wr(4'd7, BASE + 32'h100, 3, 2, 2'b01, -1);
    rd_issue(4'd8, BASE + 32'h108, 3, 2, 2'b10);
    rd_wait();

    r_stall_at = r_beats + 2;
    r_stall_left = 5;
    rd_issue(4'd9, BASE + 32'h100, 3, 2, 2'b01);
    rd_wait();
    b_stall_left = 3;
    put(32'h5555AAAA, 4'hF);
    put(32'h12345678, 4'hF);
    wr(4'd10, BASE + 32'h30, 1, 2, 2'b01, -1);

    rd_issue(4'd11, 32'h0, 0, 2, 2'b01);
    rd_wait();
    put(32'h0, 4'hF);
    wr(4'd12, BASE + 32'h20, 0, 3, 2'b01, -1);
    rd_issue(4'd12, BASE + 32'h20, 0, 2, 2'b01);
    rd_wait();

    put(32'hCAFEF00D, 4'hF);
    put(32'h0BADC0DE, 4'hF);
    wr(4'd13, BASE + 32'h40, 1, 2, 2'b01, 0);
    rd_issue(4'd13, BASE + 32'h40, 1, 2, 2'b01);
    rd_wait();

    put(32'h1, 4'hF);
    put(32'h2, 4'hF);
    put(32'h3, 4'hF);
    wr(4'd14, BASE + 32'h48, 2, 2, 2'b00, -1);
    rd_issue(4'd14, BASE + 32'h44, 2, 2, 2'b01);
    rd_wait();

    start = r_beats;
    rd_issue(4'd15, BASE, 7, 2, 2'b01);
    st = 0;
    while (r_beats < start + 2 && st < 200) begin
      @(negedge clk);
      st++;
    end
    if (r_beats < start + 2) fail("pre_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async",
          {bus.rvalid, bus.arready, bus.rlast, bus.rid},
          '0);
    rq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_release", {bus.arready, bus.rvalid}, 2'b10);
    rd_issue(4'd4, BASE + 32'h10, 1, 2, 2'b01);
    rd_wait();

    bp = 1'b1;
    for (int t = 0; t < 60; t++) begin
      size = $urandom_range(9) == 0 ? 3 : $urandom_range(2);
      burst = 2'($urandom_range(2));
      if (burst == 2'b10) len = (1 << $urandom_range(1, 3)) - 1;
      else len = $urandom_range(7);
      addr = BASE + 32'($urandom_range(40) * 4);
      if (size == 0) addr = addr + 32'($urandom_range(3));
      if (size == 1) addr = addr + 32'($urandom_range(1) * 2);
      if ($urandom_range(9) == 0) addr = BASE + 32'h0004_0000;
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i <= len; i++)
          put($urandom, 4'($urandom));
        wr(4'($urandom), addr, len, size, burst, -1);
      end else begin
        rd_issue(4'($urandom), addr, len, size, burst);
        rd_wait();
      end
    end
    bp = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
